// File: rtl/a2d_conv_sched_if.sv
// SPI monarch handshake between the A2D conversion scheduler and the SPI engine.
// master = scheduler side, slave = SPI engine side.
interface a2d_conv_sched_if;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] spi_rd;

  modport master (output spi_wrt, output spi_cmd, input spi_done, input spi_rd);
  modport slave  (input spi_wrt, input spi_cmd, output spi_done, output spi_rd);
endinterface

// File: rtl/a2d_conv_sched.sv
// Round-robin ADC128S conversion scheduler: each request runs a select + read
// SPI transaction pair and latches the 12-bit result into a per-channel register.
module a2d_conv_sched #(
  parameter logic [2:0] LFT_CH  = 3'd0,
  parameter logic [2:0] RGHT_CH = 3'd4,
  parameter logic [2:0] BATT_CH = 3'd5,
  parameter int         TMO_CYC = 2048,
  parameter int         GAP_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    nxt,
  a2d_conv_sched_if.master        spi,
  output logic [11:0]             lft_ld,
  output logic [11:0]             rght_ld,
  output logic [11:0]             batt,
  output logic                    vld,
  output logic [1:0]              vld_ch,
  output logic                    busy,
  output logic                    tmo_err
);
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {IDLE, CMD_WAIT, GAP, RD_WAIT} state_t;

  state_t         state_reg, state_next;
  logic [1:0]     ptr_reg, ptr_next, ptr_adv;
  logic           pend_reg, pend_next;
  logic           wrt_reg, wrt_next;
  logic [15:0]    cmd_reg, cmd_next;
  logic           vld_reg, vld_next;
  logic [1:0]     vld_ch_reg, vld_ch_next;
  logic           tmo_err_reg, tmo_err_next;
  logic [TW-1:0]  tmo_cnt_reg, tmo_cnt_next;
  logic [GW-1:0]  gap_cnt_reg, gap_cnt_next;
  logic [2:0]     res_we;
  logic [2:0]     ch_sel;
  logic           tmo_hit;
  logic [2:0][11:0] res_val;
  logic           rd_unused;

  // Upper nibble of the ADC frame carries no data.
  assign rd_unused = ^spi.spi_rd[15:12];

  always_comb begin
    ch_sel = LFT_CH;
    case (ptr_reg)
      2'd1:    ch_sel = RGHT_CH;
      2'd2:    ch_sel = BATT_CH;
      default: ch_sel = LFT_CH;
    endcase
  end

  assign ptr_adv = (ptr_reg == 2'd2) ? 2'd0 : ptr_reg + 2'd1;
  assign tmo_hit = (tmo_cnt_reg == TW'(TMO_CYC - 1));

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    pend_next    = pend_reg;
    wrt_next     = 1'b0;
    cmd_next     = cmd_reg;
    vld_next     = 1'b0;
    vld_ch_next  = vld_ch_reg;
    tmo_err_next = tmo_err_reg;
    tmo_cnt_next = tmo_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    res_we       = 3'b000;

    if (nxt && state_reg != IDLE) pend_next = 1'b1;

    case (state_reg)
      IDLE: begin
        if (nxt || pend_reg) begin
          wrt_next     = 1'b1;
          cmd_next     = {2'b00, ch_sel, 11'h000};
          pend_next    = 1'b0;
          tmo_cnt_next = '0;
          state_next   = CMD_WAIT;
        end
      end
      CMD_WAIT: begin
        if (spi.spi_done) begin
          gap_cnt_next = GW'(GAP_CYC);
          state_next   = GAP;
        end else if (tmo_hit) begin
          tmo_err_next = 1'b1;
          ptr_next     = ptr_adv;
          state_next   = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TW'(1);
        end
      end
      GAP: begin
        // Counter reaches zero on the edge that launches the read, leaving GAP_CYC idle cycles.
        if (gap_cnt_reg <= GW'(1)) begin
          gap_cnt_next = '0;
          wrt_next     = 1'b1;
          tmo_cnt_next = '0;
          state_next   = RD_WAIT;
        end else begin
          gap_cnt_next = gap_cnt_reg - GW'(1);
        end
      end
      RD_WAIT: begin
        if (spi.spi_done) begin
          res_we      = 3'b001 << ptr_reg;
          vld_next    = 1'b1;
          vld_ch_next = ptr_reg;
          ptr_next    = ptr_adv;
          state_next  = IDLE;
        end else if (tmo_hit) begin
          tmo_err_next = 1'b1;
          ptr_next     = ptr_adv;
          state_next   = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= 2'd0;
      pend_reg    <= 1'b0;
      wrt_reg     <= 1'b0;
      cmd_reg     <= 16'h0000;
      vld_reg     <= 1'b0;
      vld_ch_reg  <= 2'd0;
      tmo_err_reg <= 1'b0;
      tmo_cnt_reg <= '0;
      gap_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      pend_reg    <= pend_next;
      wrt_reg     <= wrt_next;
      cmd_reg     <= cmd_next;
      vld_reg     <= vld_next;
      vld_ch_reg  <= vld_ch_next;
      tmo_err_reg <= tmo_err_next;
      tmo_cnt_reg <= tmo_cnt_next;
      gap_cnt_reg <= gap_cnt_next;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_res
    logic [11:0] val_reg;
    always_ff @(posedge clk) begin
      if (rst) val_reg <= 12'h000;
      else if (res_we[gi]) val_reg <= spi.spi_rd[11:0];
    end
    assign res_val[gi] = val_reg;
  end

  assign spi.spi_wrt = wrt_reg;
  assign spi.spi_cmd = cmd_reg;
  assign lft_ld      = res_val[0];
  assign rght_ld     = res_val[1];
  assign batt        = res_val[2];
  assign vld         = vld_reg;
  assign vld_ch      = vld_ch_reg;
  assign busy        = (state_reg != IDLE);
  assign tmo_err     = tmo_err_reg;
endmodule
